// File: rtl/lv_fault_filter_if.sv
// Fault-filter bundle: raw faults and filter controls in, filtered/sticky status and interrupt out.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a level sampled each cycle.
interface lv_fault_filter_if #(
  parameter int ERR_NUM   = 14,
  parameter int FLT_CNT_W = 4
);
  logic [ERR_NUM-1:0]   i_err_raw;
  logic [FLT_CNT_W-1:0] i_flt_th;
  logic                 i_flt_byp;
  logic [ERR_NUM-1:0]   i_err_mask;
  logic [ERR_NUM-1:0]   i_err_clr;
  logic                 i_flt_en;
  logic [ERR_NUM-1:0]   o_err_flt;
  logic [ERR_NUM-1:0]   o_err_lat;
  logic                 o_err_any;
  logic                 o_int_n;

  // Register block / fault sources side.
  modport master (
    output i_err_raw, i_flt_th, i_flt_byp, i_err_mask, i_err_clr, i_flt_en,
    input  o_err_flt, o_err_lat, o_err_any, o_int_n
  );

  // Filter side.
  modport slave (
    input  i_err_raw, i_flt_th, i_flt_byp, i_err_mask, i_err_clr, i_flt_en,
    output o_err_flt, o_err_lat, o_err_any, o_int_n
  );
endinterface

// File: rtl/lv_fault_filter.sv
// Synchronize, deglitch and latch per-channel fault levels; drive active-low interrupt.
// Latency: th_eff+2 edges raw->o_err_flt with SYNC_EN=1 (2 edges in bypass); o_err_lat/o_err_any/o_int_n aligned.
// Backpressure: none; free-running level filter, every channel evaluated every cycle.
module lv_fault_filter #(
  parameter int ERR_NUM   = 14,
  parameter int FLT_CNT_W = 4,
  parameter bit SYNC_EN   = 1'b1
) (
  input logic            i_clk,
  input logic            i_rst,
  lv_fault_filter_if.slave bus
);

  // s2 is the synchronized sample the filter compares; s2_nxt is the value s2 takes on the next edge.
  logic [ERR_NUM-1:0] s2;
  logic [ERR_NUM-1:0] s2_nxt;

  generate
    if (SYNC_EN) begin : g_sync
      logic [ERR_NUM-1:0] s1;
      // Two-flop synchronizer on the asynchronous raw fault levels.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          s1 <= '0;
          s2 <= '0;
        end else begin
          s1 <= bus.i_err_raw;
          s2 <= s1;
        end
      end
      assign s2_nxt = s1;
    end else begin : g_nosync
      assign s2     = bus.i_err_raw;
      assign s2_nxt = bus.i_err_raw;
    end
  endgenerate

  logic [FLT_CNT_W-1:0] cnt_q [ERR_NUM];
  logic [FLT_CNT_W-1:0] cnt_d [ERR_NUM];
  logic [ERR_NUM-1:0]   flt_q;
  logic [ERR_NUM-1:0]   flt_d;
  logic [ERR_NUM-1:0]   lat_q;
  logic [ERR_NUM-1:0]   lat_d;
  logic                 any_q;
  logic                 int_n_q;
  logic [FLT_CNT_W-1:0] th_m1;

  // Terminal count th_eff-1, with a threshold of 0 handled as 1 (flip on the first differing sample).
  always_comb begin
    th_m1 = '0;
    if (bus.i_flt_th != '0) th_m1 = bus.i_flt_th - 1'b1;
  end

  // Per-channel stable-count filter and sticky latch next-state.
  // Bypass registers s2_nxt so that o_err_flt equals the synchronized raw level itself,
  // i.e. it sits in the same cycle as s2 rather than one register behind it.
  always_comb begin
    for (int i = 0; i < ERR_NUM; i++) begin
      cnt_d[i] = '0;
      flt_d[i] = flt_q[i];
      if (bus.i_flt_byp) begin
        flt_d[i] = s2_nxt[i];
      end else if (!bus.i_flt_en) begin
        flt_d[i] = flt_q[i];
      end else if (s2[i] == flt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < th_m1) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else begin
        flt_d[i] = s2[i];
      end
      // Set on the rising edge of the filtered level wins over a simultaneous clear.
      if (flt_d[i] && !flt_q[i]) begin
        lat_d[i] = 1'b1;
      end else if (bus.i_err_clr[i]) begin
        lat_d[i] = 1'b0;
      end else begin
        lat_d[i] = lat_q[i];
      end
    end
  end

  // State and output registers; synchronous reset overrides everything including a running count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ERR_NUM; i++) cnt_q[i] <= '0;
      flt_q   <= '0;
      lat_q   <= '0;
      any_q   <= 1'b0;
      int_n_q <= 1'b1;
    end else begin
      for (int i = 0; i < ERR_NUM; i++) cnt_q[i] <= cnt_d[i];
      flt_q   <= flt_d;
      lat_q   <= lat_d;
      any_q   <= |flt_d;
      int_n_q <= ~|(lat_d & ~bus.i_err_mask);
    end
  end

  assign bus.o_err_flt = flt_q;
  assign bus.o_err_lat = lat_q;
  assign bus.o_err_any = any_q;
  assign bus.o_int_n   = int_n_q;

endmodule

// File: doc/lv_fault_filter.md
Name: lv_fault_filter

Overview:
- Upstream front end of the low-voltage control FSM. Feeds that FSM its per-fault error levels (ow/spi/crc_wdg/pwm/vsup/hv faults).
- Synchronizes ERR_NUM raw fault indications from analog comparators, the one-wire/SPI blocks and the HV die.
- Deglitches each fault with a programmable stable-count filter and latches sticky status for register readback.
- Generates the active-low interrupt from the masked sticky status.

Parameters:
ERR_NUM, 14, number of fault channels (bit i = one fault source)
FLT_CNT_W, 4, width of the deglitch counter and of the threshold input
SYNC_EN, 1, 1: 2-flop synchronizer on raw inputs; 0: inputs used directly (sync stage becomes pass-through, latency -2)

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous reset, active-high
i_err_raw  input  ERR_NUM  raw fault levels, 1 = fault; asynchronous to i_clk
i_flt_th  input  FLT_CNT_W  deglitch threshold in cycles; 0 treated as 1
i_flt_byp  input  1  1: bypass deglitch; filtered = synchronized raw
i_err_mask  input  ERR_NUM  1 = channel excluded from interrupt (still latched)
i_err_clr  input  ERR_NUM  one-cycle W1C pulses from register block
i_flt_en  input  1  0: counters held at 0, filtered outputs frozen
o_err_flt  output  ERR_NUM  deglitched fault levels to control FSM
o_err_lat  output  ERR_NUM  sticky fault status for register readback
o_err_any  output  1  OR of o_err_flt
o_int_n  output  1  0 = unmasked latched fault pending

Behaviour:
- Reset: all sync flops, counters, o_err_flt, o_err_lat and o_err_any = 0; o_int_n = 1. Applied on the i_clk edge with i_rst=1; overrides every other input, including mid-count.
- Sync: s1 <= i_err_raw; s2 <= s1. Generated per bit only when SYNC_EN=1.
- Per-channel filter (independent counter cnt[i], FLT_CNT_W bits). Let th_eff = max(i_flt_th,1).
  - s2==flt: cnt <= 0.
  - s2!=flt and cnt < th_eff-1: cnt <= cnt+1.
  - s2!=flt and cnt >= th_eff-1: flt <= s2; cnt <= 0.
  - The filter is symmetric: assert and deassert both need th_eff consecutive differing samples.
  - A pulse shorter than th_eff synchronized cycles is rejected. Any agreeing sample restarts the count.
  - Latency, SYNC_EN=1: o_err_flt changes th_eff+2 edges after the first edge that samples the new raw level.
  - i_flt_th changed mid-count: the new value takes effect immediately. If cnt >= th_eff-1, the flip happens on the next differing sample.
  - Counter never wraps: maximum value is th_eff-1 <= 2^FLT_CNT_W-2.
- Bypass: with i_flt_byp=1, flt <= s2 every cycle and cnt <= 0. Latency 2 edges.
- Enable: with i_flt_en=0, flt holds and cnt <= 0. Bypass takes precedence over i_flt_en=0.
- Sticky latch:
  - o_err_lat[i] <= 1 on the cycle flt[i] rises. This is the same edge as o_err_flt, evaluated from next-state.
  - Otherwise o_err_lat[i] <= 0 when i_err_clr[i]=1.
  - Set wins over simultaneous clear.
  - Clear while flt still high: the latch clears and does not re-set until the next rising edge of flt.
- o_err_any = registered OR of next-state flt, aligned with o_err_flt.
- o_int_n <= ~|(next-state o_err_lat & ~i_err_mask). Registered, aligned with o_err_lat.
  - Mask changes affect o_int_n one edge later.
  - Unmasking a latched bit asserts the interrupt.

Test Plan:
- th=4, byp=0. Raw[3] high for 3 cycles, then low -> o_err_flt[3] stays 0, o_err_lat=0, o_int_n=1.
- th=4. Raw[3] held high -> o_err_flt[3]=1 and o_err_lat[3]=1 exactly 6 edges after first sample; o_int_n=0 same edge. Raw low 4+ cycles -> flt[3]=0, lat[3] stays 1.
- Lat[3]=1, mask[3]=0. Pulse clr[3] -> lat[3]=0, o_int_n=1 next edge. Repeat with clr on the flt rising edge -> lat stays 1.
- th=0 and byp=1 on ch0, ch13 -> th=0 behaves as th=1 (3-edge latency). Bypass gives 2-edge latency and passes a 1-cycle glitch.
- Mask[5]=1 with raw[5] fault -> lat[5]=1, o_int_n=1. Clear mask[5] -> o_int_n=0 one edge later.
- Counter at 2 (th=4) then i_rst=1 for 1 cycle -> all outputs 0, o_int_n=1. Raw still high -> full 6-edge latency from release.
